// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, FSM states,
// and status-register bit positions.
package dmem_pkg;

  localparam logic [31:0] IO_OUT_OFS  = 32'd0;
  localparam logic [31:0] IO_CNT_OFS  = 32'd4;
  localparam logic [31:0] IO_STAT_OFS = 32'd8;

  localparam int unsigned STAT_FAULT = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-wide RAM: asynchronous read and one synchronous write port.
// Contents are not reset; the responder sweeps zeros in after every reset.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU data-memory port: combinational loads, edge-committed
// stores, a 3-word MMIO window, sticky fault logging and a post-reset RAM clear.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h1001_0000,
  parameter logic [31:0] IO_BASE = 32'h1001_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_ena,
  input  logic        DM_W,
  input  logic        DM_R,
  input  logic [31:0] addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        init_done,
  output logic [31:0] io_out,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] RAM_LO  = {1'b0, BASE};
  localparam logic [32:0] RAM_END = {1'b0, BASE} + 33'(4 * DEPTH);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_init_done;
  logic [31:0]   r_io_out;
  logic [31:0]   r_cnt;
  logic          r_fault;
  logic [31:0]   r_fault_addr;

  logic          w_act;
  logic          w_misal;
  logic          w_ram_hit;
  logic          w_io_out_hit;
  logic          w_io_cnt_hit;
  logic          w_io_stat_hit;
  logic          w_fault;
  logic          w_ok;
  logic          w_st;
  logic          w_clr;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_ram_rdata;
  logic [31:0]   w_rd_mux;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  // Decode
  assign w_act         = DM_ena & (DM_R | DM_W) & r_init_done;
  assign w_misal       = |addr[1:0];
  assign w_ram_hit     = ({1'b0, addr} >= RAM_LO) && ({1'b0, addr} < RAM_END);
  assign w_io_out_hit  = (addr == IO_BASE + IO_OUT_OFS);
  assign w_io_cnt_hit  = (addr == IO_BASE + IO_CNT_OFS);
  assign w_io_stat_hit = (addr == IO_BASE + IO_STAT_OFS);
  assign w_ram_idx     = AW'((addr - BASE) >> 2);

  assign w_fault = w_act & (w_misal | ~(w_ram_hit | w_io_out_hit | w_io_cnt_hit | w_io_stat_hit));
  assign w_ok    = w_act & ~w_fault;
  assign w_st    = w_ok & DM_W;
  assign w_clr   = w_st & w_io_stat_hit & DM_wdata[STAT_FAULT];

  always_comb begin
    w_rd_mux = '0;
    if (w_ram_hit)          w_rd_mux = w_ram_rdata;
    else if (w_io_out_hit)  w_rd_mux = r_io_out;
    else if (w_io_cnt_hit)  w_rd_mux = r_cnt;
    else if (w_io_stat_hit) w_rd_mux[STAT_FAULT] = r_fault;
  end

  // A store with DM_R also high still returns the pre-edge word.
  assign DM_rdata = w_ok ? w_rd_mux : '0;

  // Single write port: the clear sweep owns it until RUN.
  assign w_we    = (r_state == INIT) ? 1'b1  : (w_st & w_ram_hit);
  assign w_waddr = (r_state == INIT) ? r_idx : w_ram_idx;
  assign w_wdata = (r_state == INIT) ? '0    : DM_wdata;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_ram_idx),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= INIT;
      r_idx       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end
        end
        RUN: r_init_done <= 1'b1;
        default: begin
          r_state     <= INIT;
          r_idx       <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_io_out     <= '0;
      r_cnt        <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_st && w_io_out_hit) r_io_out <= DM_wdata;
      // Setting beats clearing; only the first fault since a clear is logged.
      if (w_fault) begin
        r_fault <= 1'b1;
        if (!r_fault || w_clr) r_fault_addr <= addr;
      end else if (w_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign init_done  = r_init_done;
  assign io_out     = r_io_out;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random accesses, all
// checked against a word-level reference model of the memory map.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h1001_0000;
  localparam logic [31:0] IO_BASE = 32'h1001_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DM_ena = 1'b0, DM_W = 1'b0, DM_R = 1'b0;
  logic [31:0] addr = '0, DM_wdata = '0;
  logic [31:0] DM_rdata, io_out, fault_addr;
  logic        init_done, fault;

  dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .DM_ena(DM_ena), .DM_W(DM_W), .DM_R(DM_R),
    .addr(addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
    .init_done(init_done), .io_out(io_out), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_io, m_cyc, m_faddr;
  logic        m_fault;
  int          m_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_done();
    return m_edges >= int'(DEPTH);
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return (a == IO_BASE) || (a == IO_BASE + 32'd4) || (a == IO_BASE + 32'd8);
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !(is_ram(a) || is_io(a));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_ram(a))              return m_mem[(a - BASE) / 4];
    if (a == IO_BASE)           return m_io;
    if (a == IO_BASE + 32'd4)   return m_cyc;
    return {31'b0, m_fault};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    m_io = '0; m_cyc = '0; m_fault = 1'b0; m_faddr = '0; m_edges = 0;
  endtask

  // Drives one cycle of port activity starting just after a rising edge.
  task automatic access(input string tag, input bit en, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] wd);
    bit act, flt;
    logic [31:0] exp_rd;
    DM_ena = en; DM_R = r; DM_W = w; addr = a; DM_wdata = wd;
    #2;
    act = en && (r || w) && m_done();
    flt = act && is_fault(a);
    exp_rd = (act && !flt) ? m_read(a) : 32'h0;
    chk({tag, ".rdata"}, DM_rdata, exp_rd);
    @(posedge clk);
    if (flt) begin
      if (!m_fault) m_faddr = a;
      m_fault = 1'b1;
    end else if (act && w) begin
      if (is_ram(a))                           m_mem[(a - BASE) / 4] = wd;
      else if (a == IO_BASE)                   m_io = wd;
      else if (a == IO_BASE + 32'd8 && wd[0])  m_fault = 1'b0;
    end
    m_cyc = m_cyc + 32'd1;
    m_edges++;
    #1;
    chk({tag, ".init_done"}, {31'b0, init_done}, {31'b0, m_done()});
    chk({tag, ".io_out"}, io_out, m_io);
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
    chk({tag, ".fault_addr"}, fault_addr, m_faddr);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".init_done"}, {31'b0, init_done}, 32'h0);
    chk({tag, ".io_out"}, io_out, 32'h0);
    chk({tag, ".fault"}, {31'b0, fault}, 32'h0);
    chk({tag, ".fault_addr"}, fault_addr, 32'h0);
    chk({tag, ".rdata"}, DM_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    m_reset();
    DM_ena = 1'b1; DM_R = 1'b1; addr = IO_BASE;
    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Stores during the clear sweep must vanish.
    for (int i = 0; i < int'(DEPTH); i++) access("init_st", 1, 0, 1, BASE, 32'hA5A5_0000 + i);
    chk("first_cnt_model", m_cyc, 32'(DEPTH));
    access("first_cnt", 1, 1, 0, IO_BASE + 32'd4, 32'h0);
    access("base_zero", 1, 1, 0, BASE, 32'h0);
    for (int i = 0; i < 4; i++) access("run_idle", 0, 0, 0, BASE, 32'h0);

    access("st_dead", 1, 0, 1, BASE + 32'd8, 32'hDEAD_BEEF);
    access("ld_dead", 1, 1, 0, BASE + 32'd8, 32'h0);
    access("st_noena", 0, 0, 1, BASE + 32'd8, 32'h1234_5678);
    access("ld_dead2", 1, 1, 0, BASE + 32'd8, 32'h0);
    access("st_rw", 1, 1, 1, BASE + 32'd8, 32'h0BAD_F00D);
    access("ld_rw", 1, 1, 0, BASE + 32'd8, 32'h0);

    access("st_io", 1, 0, 1, IO_BASE, 32'h5);
    access("ld_cnt0", 1, 1, 0, IO_BASE + 32'd4, 32'h0);
    access("ld_cnt1", 1, 1, 0, IO_BASE + 32'd4, 32'h0);
    access("st_cnt", 1, 0, 1, IO_BASE + 32'd4, 32'hFFFF_0000);
    access("ld_cnt2", 1, 1, 0, IO_BASE + 32'd4, 32'h0);

    access("ld_mis", 1, 1, 0, BASE + 32'd2, 32'h0);
    access("st_unmap", 1, 0, 1, 32'h0, 32'h77);
    access("ld_stat", 1, 1, 0, IO_BASE + 32'd8, 32'h0);
    access("clr0", 1, 0, 1, IO_BASE + 32'd8, 32'h0);
    access("clr1", 1, 0, 1, IO_BASE + 32'd8, 32'h1);
    access("ld_end", 1, 1, 0, BASE + 32'(4 * DEPTH), 32'h0);
    access("st_io9", 1, 0, 1, IO_BASE + 32'd9, 32'h1);
    access("clr2", 1, 0, 1, IO_BASE + 32'd8, 32'h1);

    force dut.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cnt;
    m_cyc = 32'hFFFF_FFFF;
    access("cnt_max", 1, 1, 0, IO_BASE + 32'd4, 32'h0);
    access("cnt_wrap", 1, 1, 0, IO_BASE + 32'd4, 32'h0);

    // Mid-run reset with live RAM, io_out and fault state.
    access("pre_st", 1, 0, 1, BASE + 32'd12, 32'hCAFE_0001);
    access("pre_io", 1, 0, 1, IO_BASE, 32'h9999);
    access("pre_flt", 1, 1, 0, 32'h4, 32'h0);
    DM_ena = 1'b1; DM_R = 1'b1; DM_W = 1'b0; addr = IO_BASE;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clk); #1;
    chk_reset_state("midrst_hold");
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < int'(DEPTH); i++) access("reinit", (i % 97) == 0, 1, 0, IO_BASE, 32'h0);
    access("post_ram", 1, 1, 0, BASE + 32'd12, 32'h0);
    access("post_cnt", 1, 1, 0, IO_BASE + 32'd4, 32'h0);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3, 4: a = BASE + 32'(4 * $urandom_range(0, 15));
        5:             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        6:             a = IO_BASE + 32'(4 * $urandom_range(0, 2));
        7:             a = IO_BASE + 32'd8;
        8:             a = $urandom;
        default:       a = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * DEPTH) - 32'd4 : BASE - 32'd4;
      endcase
      access("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle CPU: the target end of the CPU's `DM_*` data-memory port. It serves word loads combinationally in the same cycle and commits stores on the clock edge. It maps a small MMIO window (output register, free-running cycle counter, fault status) and zero-fills its RAM after every reset with a sweep state machine. The top level holds the CPU in reset until `init_done` is high.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `BASE`, 32'h1001_0000: byte address of RAM word 0.
- `IO_BASE`, 32'h1001_F000: byte address of the MMIO window, 3 words. Must not overlap the RAM range.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low.
- `DM_ena`  in  1: access enable from the CPU.
- `DM_W`  in  1: store request.
- `DM_R`  in  1: load request.
- `addr`  in  32: byte address, driven from the CPU ALU result.
- `DM_wdata`  in  32: store data.
- `DM_rdata`  out  32: load data, combinational.
- `init_done`  out  1: RAM clear complete; CPU may run.
- `io_out`  out  32: MMIO output register.
- `fault`  out  1: sticky access-fault flag.
- `fault_addr`  out  32: address of the first fault since it was last cleared.

## Operation
- An access is `act = DM_ena & (DM_R | DM_W) & init_done`.
- Decode:
  - RAM hit: `BASE <= addr < BASE + 4*DEPTH`; index = `(addr - BASE) >> 2`.
  - MMIO hit: `addr` equals `IO_BASE + 0`, `+4` or `+8`.
  - Anything else is unmapped.
- Misaligned access (`addr[1:0] != 0`) or an unmapped address is a fault.
- Loads:
  - `DM_rdata` shows the addressed word whenever `act` is high and the access is not a fault.
  - Otherwise `DM_rdata` = 0.
  - If `DM_R` and `DM_W` are both high, the access is a store; `DM_rdata` still shows the old word.
- Stores commit at the rising edge; faulting stores are dropped.
- MMIO map:
  - `+0` `io_out`: read/write.
  - `+4` cycle counter: read-only; writes are ignored without a fault.
  - `+8` status: bit0 = `fault`, other bits read 0; writing 1 to bit0 clears `fault`.
- Fault logging:
  - On a faulting `act`, `fault` sets at the next edge.
  - `fault_addr` captures `addr` only if `fault` was 0; later faults do not overwrite it.
  - If a fault and a W1C clear happen in the same cycle, set wins and `fault_addr` reloads.
- Cycle counter: 32-bit, increments every cycle after reset, wraps from 0xFFFF_FFFF to 0.
- FSM:
  - INIT: writes 0 to RAM[idx], idx++. After writing DEPTH-1, moves to RUN.
  - RUN: serves accesses; `init_done` = 1.
  - While in INIT, every CPU access is ignored: `DM_rdata` = 0, no store, no fault.

## Timing
- Reset values: state INIT, idx 0, `init_done` 0, `io_out` 0, counter 0, `fault` 0, `fault_addr` 0, `DM_rdata` 0.
- `init_done` rises after the DEPTH-th rising edge following `rst` deassertion.
- Load latency is 0 cycles (combinational). Store latency is 1 edge; a load of the same word in the next cycle returns the new data.
- Counter reads return the pre-edge value. The first RUN cycle reads DEPTH.
- A mid-operation `rst` assertion returns to INIT, restarts the clear and resets all registers.

## Structure
- Shared package `dmem_pkg`:
  - MMIO offsets `IO_OUT_OFS` = 0, `IO_CNT_OFS` = 4, `IO_STAT_OFS` = 8.
  - FSM state enum `{INIT, RUN}`.
  - Status bit index `STAT_FAULT` = 0.
- Sub-module `dmem_ram`:
  - `DEPTH` x 32 array, asynchronous read, synchronous write.
  - One write port, muxed between the INIT sweep and CPU stores.
- Decode, MMIO registers, counter, fault logic and FSM live in `dmem_responder`.

## Test plan
- Reset, then run 1030 cycles with DEPTH = 1024 → `init_done` rises after edge 1024. Earlier `DM_W` to BASE is dropped, and a later load of BASE returns 0.
- Store 0xDEADBEEF to BASE+8, then load BASE+8 the next cycle → `DM_rdata` = 0xDEADBEEF. A store with `DM_ena` = 0 changes nothing.
- Store 0x5 to IO_BASE → `io_out` = 0x5 after the edge. Load IO_BASE+4 on consecutive cycles → the counter differs by 1. A store to IO_BASE+4 has no effect and `fault` stays 0.
- Fault logging:
  - Load at BASE+2 → `fault` = 1, `fault_addr` = BASE+2, `DM_rdata` = 0.
  - Then store to 0x0 → `fault_addr` stays BASE+2.
  - Store 1 to IO_BASE+8 → `fault` = 0.
- Same-cycle W1C clear and new fault: store 1 to IO_BASE+8 while... (single port) — instead set `fault`, then issue a misaligned store to IO_BASE+9 → `fault` stays 1, `fault_addr` unchanged. Force the counter to 0xFFFF_FFFF → it wraps to 0.
- Assert `rst` mid-RUN after writing RAM and `io_out` → all outputs return to reset values, INIT restarts, and RAM reads 0 after `init_done`.
